cs_window_filter: RTL
=====================

// Module: cs_window_filter
// PURPOSE
//  Parametrised sliding-window "computational system" filter, the next generation of the CS block.
//  - Keeps the last DEPTH accepted samples and their running sum.
//  - Emits one result per accepted sample once the window is full.
//  - Two modes:
//    - CS approximation: Y = (DEPTH*Xappr + sum) >> log2(DEPTH-1).
//    - Plain average: Y = floor(sum/DEPTH).
//  - Sits between the sample source and downstream logic. Valid-qualified input, fully synchronous output.
// PARAMETERS
//  DATA_W  8  sample width, unsigned.
//  DEPTH   9  window length. Legal values are 3, 5, 9 and 17 (DEPTH-1 must be a power of 2); any other value is an elaboration error.
//  localparams:
//   SUM_W = DATA_W + $clog2(DEPTH)
//   OUT_W = DATA_W + 2
//   SH    = $clog2(DEPTH-1)
// PORTS
//  clk        in   1       clock, rising edge only
//  reset      in   1       asynchronous, active-low reset
//  in_valid   in   1       X is sampled at this rising edge
//  X          in   DATA_W  input sample
//  mode       in   1       0 = CS approximation, 1 = plain average; sampled together with X
//  out_valid  out  1       Y is valid this cycle (one-cycle pulse)
//  Y          out  OUT_W   result
//  win_full   out  1       window holds DEPTH valid samples
// BEHAVIOUR
//  Reset (reset=0, async assert, sync release):
//   - window regs, sum, fill count, Y, out_valid, win_full all 0; state = FILL.
//  FSM:
//   - FILL: count accepted samples.
//   - FILL->RUN on the accept that makes count == DEPTH.
//   - RUN stays in RUN until reset (or flush).
//  Accept: on a rising edge with in_valid=1:
//   - shift X into slot 0; slots move up; slot DEPTH-1 drops out.
//   - sum <= sum - slot[DEPTH-1] + X. Exact, no overflow: SUM_W is sized for DEPTH*(2^DATA_W-1).
//  in_valid=0: window, sum, count and Y all hold; out_valid = 0.
//  Xappr:
//   - largest window sample <= floor(sum/DEPTH).
//   - Always exists because min <= average.
//   - Combinational from the window regs.
//  Result:
//   - mode 0: Y = (DEPTH*Xappr + sum) >> SH, truncating.
//   - mode 1: Y = floor(sum/DEPTH), zero-extended.
//   - The mode used is the one registered with the same accepted sample.
//  Latency:
//   - A sample accepted at edge k updates Y at edge k+1.
//   - out_valid=1 for exactly one cycle after edge k+1, only if the window was full after edge k.
//   - The first out_valid follows the DEPTH-th accepted sample. Back-to-back accepts give back-to-back out_valid.
//  Y holds its last value whenever out_valid=0. All outputs change on posedge only.
//  win_full = 1 in RUN, 0 in FILL.
//  Reset mid-stream: immediate clear. The next result needs DEPTH fresh samples.
// CONFIGURATION
//  CS_FLUSH_EN defined:
//   - adds input port flush (1 bit).
//   - flush=1 at an edge: synchronously clears window, sum and count; state -> FILL; Y holds; out_valid=0 the next cycle.
//   - flush and in_valid in the same cycle: flush wins and the sample is dropped.
//   - Any result pending from the previous edge still appears.
//  CS_FLUSH_EN undefined: no flush port; the window is cleared only by reset.
// TESTING (DEPTH=9, DATA_W=8)
//  1. Reset, then X=1..9 on consecutive edges, mode=0 -> no out_valid for samples 1-8; after sample 9: sum=45, Xappr=5, Y=90>>3=11, out_valid 1 cycle.
//  2. Nine samples of 100 then X=190, mode=0 -> first Y=1800>>3=225; next sum=990, avg=110, Xappr=100, Y=1890>>3=236.
//  3. Nine samples of 255, mode=1 -> Y=255; then mode=0 -> Y=4590>>3=573. Checks full-scale width, no wrap.
//  4. Full window, then in_valid low for 5 cycles -> Y, sum and win_full unchanged, out_valid 0; the next accept resumes with a result 1 cycle later.
//  5. Drop reset to 0 after the 6th accept -> every output is 0 at once; a fresh 1..9 sequence reproduces Y=11.
//  6. CS_FLUSH_EN: full window, then flush with in_valid=1, X=50 -> win_full=0; X=50 is not counted; 9 more samples are needed before out_valid.

Source files
------------

// File: rtl/cs_window_filter.sv
// Sliding-window CS filter: keeps the last DEPTH samples and emits a CS approximation or a plain average.
// Optional synchronous window flush is enabled by defining CS_FLUSH_EN.
module cs_window_filter #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 9
) (
  input  logic              clk,
  input  logic              reset,
`ifdef CS_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              in_valid,
  input  logic [DATA_W-1:0] X,
  input  logic              mode,
  output logic              out_valid,
  output logic [DATA_W+1:0] Y,
  output logic              win_full
);

  localparam int unsigned SUM_W = DATA_W + $clog2(DEPTH);
  localparam int unsigned OUT_W = DATA_W + 2;
  localparam int unsigned SH    = $clog2(DEPTH - 1);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned ACC_W = SUM_W + 1;

  if (DEPTH != 3 && DEPTH != 5 && DEPTH != 9 && DEPTH != 17) begin : g_bad_depth
    $error("cs_window_filter: DEPTH must be 3, 5, 9 or 17");
  end

  typedef enum logic {FILL, RUN} state_t;

  state_t              state;
  logic [DATA_W-1:0]   win [DEPTH];
  logic [SUM_W-1:0]    sum;
  logic [CNT_W-1:0]    count;
  logic                mode_r;
  logic                pending;
  logic                flush_req;
  logic                accept;
  logic                full_after;
  logic [SUM_W-1:0]    avg;
  logic [DATA_W-1:0]   xappr;
  logic [ACC_W-1:0]    acc;
  logic [OUT_W-1:0]    y_cs;
  logic [OUT_W-1:0]    y_avg;

`ifdef CS_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  assign accept     = in_valid && !flush_req;
  assign full_after = (state == RUN) || (count == CNT_W'(DEPTH - 1));
  assign win_full   = (state == RUN);

  // Xappr: largest window sample not above the floor average; min <= avg guarantees a hit.
  always_comb begin
    avg   = sum / SUM_W'(DEPTH);
    xappr = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (SUM_W'(win[i]) <= avg && win[i] > xappr)
        xappr = win[i];
    end
    acc   = ACC_W'(DEPTH) * ACC_W'(xappr) + ACC_W'(sum);
    y_cs  = OUT_W'(acc >> SH);
    y_avg = OUT_W'(avg);
  end

  // Result for the sample accepted at edge k is formed at edge k+1 from the already-updated window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FILL;
      sum       <= '0;
      count     <= '0;
      mode_r    <= 1'b0;
      pending   <= 1'b0;
      out_valid <= 1'b0;
      Y         <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) win[i] <= '0;
    end else begin
      out_valid <= pending;
      if (pending)
        Y <= mode_r ? y_avg : y_cs;

      if (flush_req) begin
        state   <= FILL;
        sum     <= '0;
        count   <= '0;
        pending <= 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) win[i] <= '0;
      end else begin
        pending <= accept && full_after;
        if (accept) begin
          win[0] <= X;
          for (int unsigned i = DEPTH - 1; i > 0; i--) win[i] <= win[i-1];
          sum    <= sum - SUM_W'(win[DEPTH-1]) + SUM_W'(X);
          mode_r <= mode;
          if (state == FILL) begin
            count <= count + CNT_W'(1);
            if (count == CNT_W'(DEPTH - 1))
              state <= RUN;
          end
        end
      end
    end
  end

endmodule
